// File: rtl/sd_blk_arbiter_pkg.sv
// Shared types and constants for the SD block-channel arbiter and its round-robin picker.
package sd_blk_arbiter_pkg;

  localparam int MAX_DRIVES = 4;
  localparam int GRANT_W    = 2;
  localparam int TIMEOUT_W  = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    XFER    = 3'd2,
    RELEASE = 3'd3,
    FLUSH   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sd_blk_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req_i searching upward from last_i + 1.
module rr_pick
  import sd_blk_arbiter_pkg::*;
#(
  parameter int N = MAX_DRIVES
) (
  input  logic [N-1:0]       req_i,
  input  logic [GRANT_W-1:0] last_i,
  output logic               valid_o,
  output logic [GRANT_W-1:0] idx_o
);

  logic [MAX_DRIVES-1:0] req_ext;
  logic [GRANT_W-1:0]    cand;

  assign req_ext = MAX_DRIVES'(req_i);

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = GRANT_W'((int'(last_i) + k) % N);
      if (req_ext[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/sd_blk_arbiter.sv
// Four-to-one arbiter from per-drive SD block request ports onto the single host SD block channel.
// Optional watchdog on REQ/XFER enabled by defining SD_ARB_TIMEOUT_EN.
module sd_blk_arbiter
  import sd_blk_arbiter_pkg::*;
#(
  parameter int                   NUM_DRIVES     = 4,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd16777215
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [32*NUM_DRIVES-1:0] drv_lba,
  input  logic [NUM_DRIVES-1:0]   drv_rd,
  input  logic [NUM_DRIVES-1:0]   drv_wr,
  output logic [NUM_DRIVES-1:0]   drv_ack,
  output logic [NUM_DRIVES-1:0]   drv_buff_wr,
  input  logic [8*NUM_DRIVES-1:0] drv_buff_din,
  output logic [31:0]             sd_lba,
  output logic                    sd_rd,
  output logic                    sd_wr,
  input  logic                    sd_ack,
  input  logic                    sd_buff_wr,
  output logic [7:0]              sd_buff_din,
  output logic                    busy,
  output logic [1:0]              grant,
  output logic [2:0]              dbg_state_o
`ifdef SD_ARB_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  // Handshake: a drive holds rd/wr until it sees its ack; once sd_rd/sd_wr is raised to the
  // host it stays high until sd_ack, and the transfer lasts as long as sd_ack stays high.

  arb_state_t         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [31:0]        lba_q, lba_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               busy_q;

  logic [31:0]           lba_arr [MAX_DRIVES];
  logic [7:0]            din_arr [MAX_DRIVES];
  logic [MAX_DRIVES-1:0] rd_ext;
  logic [MAX_DRIVES-1:0] ack_ext;
  logic [MAX_DRIVES-1:0] bwr_ext;
  logic                  pick_valid;
  logic [GRANT_W-1:0]    pick_idx;

  for (genvar i = 0; i < MAX_DRIVES; i++) begin : g_arr
    if (i < NUM_DRIVES) begin : g_on
      assign lba_arr[i] = drv_lba[32*i +: 32];
      assign din_arr[i] = drv_buff_din[8*i +: 8];
    end else begin : g_off
      assign lba_arr[i] = '0;
      assign din_arr[i] = '0;
    end
  end

  assign rd_ext = MAX_DRIVES'(drv_rd);

  rr_pick #(.N(NUM_DRIVES)) u_pick (
    .req_i   (drv_rd | drv_wr),
    .last_i  (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

`ifdef SD_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = REQ;
          grant_d = pick_idx;
          ptr_d   = pick_idx;
          lba_d   = lba_arr[pick_idx];
          rd_d    = rd_ext[pick_idx];
          wr_d    = ~rd_ext[pick_idx];
        end
      end
      REQ: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end
      end
      XFER:    if (!sd_ack) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      FLUSH:   if (!sd_ack) state_d = IDLE;
      default: begin
        state_d = FLUSH;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
`ifdef SD_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == REQ || state_q == XFER) begin
      cnt_d = cnt_q + 1'b1;
      // Abandon the transfer; the drive still holds its request and is re-arbitrated.
      if (cnt_d == TIMEOUT_CYCLES) begin
        tmo_d   = 1'b1;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = FLUSH;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= FLUSH;
      grant_q <= '0;
      ptr_q   <= GRANT_W'(NUM_DRIVES - 1);
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= (state_d != IDLE);
`ifdef SD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Host ack can rise while still in REQ, so routing is open in both REQ and XFER.
  always_comb begin
    ack_ext     = '0;
    bwr_ext     = '0;
    sd_buff_din = 8'h00;
    if (state_q == REQ || state_q == XFER) begin
      ack_ext[grant_q] = sd_ack;
      bwr_ext[grant_q] = sd_buff_wr;
      sd_buff_din      = din_arr[grant_q];
    end
  end

  assign drv_ack     = ack_ext[NUM_DRIVES-1:0];
  assign drv_buff_wr = bwr_ext[NUM_DRIVES-1:0];
  assign sd_lba      = lba_q;
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign busy        = busy_q;
  assign grant       = grant_q;
  assign dbg_state_o = state_q;
`ifdef SD_ARB_TIMEOUT_EN
  assign timeout_err = tmo_q;
`endif

endmodule

// File: tb/tb_sd_blk_arbiter.sv
// Self-checking bench for sd_blk_arbiter: directed scenarios plus randomized rounds against a
// round-robin reference model.
module tb_sd_blk_arbiter;

  typedef struct packed {
    logic [3:0]  ack_or;
    int          ack_hits;
    int          pulses;
    int          bwr_hits;
    int          bwr_stray;
    logic [3:0]  bwr_or;
    logic [7:0]  din;
    logic        req_after;
    logic        ack_low;
    logic        rel_busy;
    logic        rel_req;
    logic        idle_busy;
    logic        idle_req;
  } obs_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] lba;
    logic        rd;
    logic        wr;
    logic [7:0]  din;
  } exp_t;

  logic         CLK;
  logic         RESET_N;
  logic [127:0] drv_lba;
  logic [3:0]   drv_rd;
  logic [3:0]   drv_wr;
  logic [3:0]   drv_ack;
  logic [3:0]   drv_buff_wr;
  logic [31:0]  drv_buff_din;
  logic [31:0]  sd_lba;
  logic         sd_rd;
  logic         sd_wr;
  logic         sd_ack;
  logic         sd_buff_wr;
  logic [7:0]   sd_buff_din;
  logic         busy;
  logic [1:0]   grant;
  logic [2:0]   dbg_state;
`ifdef SD_ARB_TIMEOUT_EN
  logic         timeout_err;
`endif

  int   errors;
  int   checks;
  exp_t exp_q[$];

  sd_blk_arbiter #(.NUM_DRIVES(4), .TIMEOUT_CYCLES(24'd100)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .drv_lba      (drv_lba),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_wr  (drv_buff_wr),
    .drv_buff_din (drv_buff_din),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .grant        (grant),
    .dbg_state_o  (dbg_state)
`ifdef SD_ARB_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the arbiter in IDLE at the returned sample point.
  task automatic do_reset();
    RESET_N = 1'b0;
    drv_rd = '0;
    drv_wr = '0;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic wait_req(input int budget, output bit ok, output int cyc);
    cyc = 0;
    while (cyc < budget && !(sd_rd | sd_wr)) begin
      tick();
      cyc++;
    end
    ok = sd_rd | sd_wr;
  endtask

  // Host driver: waits delay cycles in REQ, acks for len cycles with buffer strobes,
  // then records the two cycles after the ack falls.
  task automatic host_xfer(input int delay, input int len, input int drop_idx, output obs_t o);
    o = '0;
    repeat (delay) tick();
    sd_ack = 1'b1;
    for (int i = 0; i < len; i++) begin
      sd_buff_wr = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (drv_ack != 4'b0) o.ack_hits++;
      o.ack_or |= drv_ack;
      if (sd_buff_wr) begin
        o.pulses++;
        o.bwr_or |= drv_buff_wr;
        if (drv_buff_wr != 4'b0) o.bwr_hits++;
      end else if (drv_buff_wr != 4'b0) begin
        o.bwr_stray++;
      end
      if (i == 0) begin
        o.din = sd_buff_din;
        if (drop_idx >= 0) begin
          drv_rd[drop_idx] = 1'b0;
          drv_wr[drop_idx] = 1'b0;
        end
      end
      tick();
      if (i == 0) o.req_after = sd_rd | sd_wr;
    end
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    #1;
    o.ack_low = |drv_ack;
    tick();
    o.rel_busy = busy;
    o.rel_req = sd_rd | sd_wr;
    tick();
    o.idle_busy = busy;
    o.idle_req = sd_rd | sd_wr;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick();
    checks++; if (sd_rd !== 1'b0) begin errors++; $display("FAIL reset_sd_rd got=%h exp=0", sd_rd); end
    checks++; if (sd_wr !== 1'b0) begin errors++; $display("FAIL reset_sd_wr got=%h exp=0", sd_wr); end
    checks++; if (drv_ack !== 4'b0) begin errors++; $display("FAIL reset_drv_ack got=%h exp=0", drv_ack); end
    checks++; if (drv_buff_wr !== 4'b0) begin errors++; $display("FAIL reset_drv_buff_wr got=%h exp=0", drv_buff_wr); end
    checks++; if (sd_lba !== 32'h0) begin errors++; $display("FAIL reset_sd_lba got=%h exp=0", sd_lba); end
    checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (sd_buff_din !== 8'h00) begin errors++; $display("FAIL reset_sd_buff_din got=%h exp=00", sd_buff_din); end
    RESET_N = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%h exp=0", busy); end
  endtask

  task automatic test_single_read();
    obs_t o;
    do_reset();
    drv_lba[64 +: 32] = 32'h0000_0123;
    drv_rd = 4'b0100;
    #1;
    checks++; if (sd_rd !== 1'b0) begin errors++; $display("FAIL single_early_rd got=%h exp=0", sd_rd); end
    tick();
    checks++; if (sd_rd !== 1'b1) begin errors++; $display("FAIL single_sd_rd got=%h exp=1", sd_rd); end
    checks++; if (sd_wr !== 1'b0) begin errors++; $display("FAIL single_sd_wr got=%h exp=0", sd_wr); end
    checks++; if (sd_lba !== 32'h123) begin errors++; $display("FAIL single_sd_lba got=%h exp=123", sd_lba); end
    checks++; if (grant !== 2'd2) begin errors++; $display("FAIL single_grant got=%0d exp=2", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%h exp=1", busy); end
    repeat (4) tick();
    checks++; if (sd_rd !== 1'b1 || drv_ack !== 4'b0) begin errors++; $display("FAIL single_hold got rd=%h ack=%h exp rd=1 ack=0", sd_rd, drv_ack); end
    host_xfer(0, 10, 2, o);
    checks++; if (o.ack_or !== 4'b0100) begin errors++; $display("FAIL single_ack_bits got=%b exp=0100", o.ack_or); end
    checks++; if (o.ack_hits != 10) begin errors++; $display("FAIL single_ack_len got=%0d exp=10", o.ack_hits); end
    checks++; if (o.ack_low !== 1'b0) begin errors++; $display("FAIL single_ack_after got=%h exp=0", o.ack_low); end
    checks++; if (o.req_after !== 1'b0) begin errors++; $display("FAIL single_req_clear got=%h exp=0", o.req_after); end
    checks++; if (o.rel_busy !== 1'b1 || o.idle_busy !== 1'b0) begin errors++; $display("FAIL single_busy_tail got=%h%h exp=10", o.rel_busy, o.idle_busy); end
    checks++; if (grant !== 2'd2) begin errors++; $display("FAIL single_grant_kept got=%0d exp=2", grant); end
  endtask

  task automatic test_contention();
    obs_t o;
    bit ok;
    int cyc;
    logic [31:0] lba [4];
    do_reset();
    for (int d = 0; d < 4; d++) begin
      lba[d] = $urandom;
      drv_lba[32*d +: 32] = lba[d];
    end
    drv_rd = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_req(8, ok, cyc);
      checks++; if (!ok) begin errors++; $display("FAIL cont_req_%0d got=none exp=request", i); end
      checks++; if (cyc != 1) begin errors++; $display("FAIL cont_latency_%0d got=%0d exp=1", i, cyc); end
      checks++; if (grant !== 2'(i)) begin errors++; $display("FAIL cont_grant_%0d got=%0d exp=%0d", i, grant, i); end
      checks++; if (sd_lba !== lba[i]) begin errors++; $display("FAIL cont_lba_%0d got=%h exp=%h", i, sd_lba, lba[i]); end
      host_xfer($urandom_range(0, 3), $urandom_range(1, 5), i, o);
      checks++; if (o.ack_or !== 4'(1 << i)) begin errors++; $display("FAIL cont_ack_%0d got=%b exp=%b", i, o.ack_or, 4'(1 << i)); end
      checks++; if (o.rel_req !== 1'b0 || o.idle_req !== 1'b0) begin errors++; $display("FAIL cont_gap_%0d got=%h%h exp=00", i, o.rel_req, o.idle_req); end
    end
  endtask

  task automatic test_buff_routing();
    obs_t o;
    bit ok;
    int cyc;
    do_reset();
    drv_buff_din = 32'hFFFF_A5FF;
    drv_lba[32 +: 32] = 32'h0BAD_F00D;
    #1;
    checks++; if (sd_buff_din !== 8'h00) begin errors++; $display("FAIL buf_idle_din got=%h exp=00", sd_buff_din); end
    drv_wr = 4'b0010;
    wait_req(8, ok, cyc);
    checks++; if (sd_wr !== 1'b1 || sd_rd !== 1'b0) begin errors++; $display("FAIL buf_op got rd=%h wr=%h exp rd=0 wr=1", sd_rd, sd_wr); end
    checks++; if (grant !== 2'd1) begin errors++; $display("FAIL buf_grant got=%0d exp=1", grant); end
    host_xfer(1, 4, 1, o);
    checks++; if (o.din !== 8'hA5) begin errors++; $display("FAIL buf_din got=%h exp=a5", o.din); end
    checks++; if (o.bwr_or !== 4'b0010) begin errors++; $display("FAIL buf_wr_bits got=%b exp=0010", o.bwr_or); end
    checks++; if (o.bwr_hits != o.pulses || o.bwr_stray != 0) begin errors++; $display("FAIL buf_wr_count got=%0d/%0d stray=%0d exp equal, stray 0", o.bwr_hits, o.pulses, o.bwr_stray); end
    checks++; if (sd_buff_din !== 8'h00) begin errors++; $display("FAIL buf_after_din got=%h exp=00", sd_buff_din); end
  endtask

  task automatic test_rd_wr_same();
    obs_t o;
    bit ok;
    int cyc;
    do_reset();
    drv_lba[96 +: 32] = 32'hCAFE_0003;
    drv_rd = 4'b1000;
    drv_wr = 4'b1000;
    wait_req(8, ok, cyc);
    checks++; if (sd_rd !== 1'b1 || sd_wr !== 1'b0) begin errors++; $display("FAIL rdwr_op got rd=%h wr=%h exp rd=1 wr=0", sd_rd, sd_wr); end
    checks++; if (grant !== 2'd3) begin errors++; $display("FAIL rdwr_grant got=%0d exp=3", grant); end
    host_xfer(0, 2, 3, o);
    checks++; if (o.ack_or !== 4'b1000) begin errors++; $display("FAIL rdwr_ack got=%b exp=1000", o.ack_or); end
  endtask

  task automatic test_reset_mid_xfer();
    obs_t o;
    bit ok;
    int cyc;
    do_reset();
    drv_lba[32 +: 32] = 32'h1111_2222;
    drv_rd = 4'b0010;
    wait_req(8, ok, cyc);
    sd_ack = 1'b1;
    tick();
    checks++; if (drv_ack !== 4'b0010) begin errors++; $display("FAIL rmx_ack_before got=%b exp=0010", drv_ack); end
    RESET_N = 1'b0;
    tick();
    checks++; if ({sd_rd, sd_wr, busy} !== 3'b0 || drv_ack !== 4'b0 || drv_buff_wr !== 4'b0) begin
      errors++; $display("FAIL rmx_reset_out got rd=%h wr=%h busy=%h ack=%b bwr=%b exp all 0", sd_rd, sd_wr, busy, drv_ack, drv_buff_wr);
    end
    checks++; if (sd_lba !== 32'h0 || grant !== 2'd0) begin errors++; $display("FAIL rmx_reset_regs got lba=%h grant=%0d exp 0 0", sd_lba, grant); end
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (drv_ack !== 4'b0 || sd_rd !== 1'b0) begin errors++; $display("FAIL rmx_flush_%0d got ack=%b rd=%h exp 0 0", i, drv_ack, sd_rd); end
    end
    sd_ack = 1'b0;
    tick();
    checks++; if (sd_rd !== 1'b0) begin errors++; $display("FAIL rmx_idle_rd got=%h exp=0", sd_rd); end
    tick();
    checks++; if (sd_rd !== 1'b1 || grant !== 2'd1) begin errors++; $display("FAIL rmx_regrant got rd=%h grant=%0d exp 1 1", sd_rd, grant); end
    host_xfer(0, 2, 1, o);
    checks++; if (o.ack_or !== 4'b0010) begin errors++; $display("FAIL rmx_ack_after got=%b exp=0010", o.ack_or); end
  endtask

`ifdef SD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    bit ok;
    int cyc;
    int cnt;
    do_reset();
    drv_lba[31:0] = 32'h0000_7777;
    drv_rd = 4'b0001;
    wait_req(8, ok, cyc);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_before got=%h exp=0", timeout_err); end
    cnt = 0;
    while (sd_rd && cnt < 200) begin
      tick();
      cnt++;
    end
    checks++; if (cnt != 100) begin errors++; $display("FAIL tmo_cycles got=%0d exp=100", cnt); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag got=%h exp=1", timeout_err); end
    wait_req(8, ok, cyc);
    checks++; if (!ok || cyc != 2 || grant !== 2'd0) begin errors++; $display("FAIL tmo_reissue got ok=%0d cyc=%0d grant=%0d exp 1 2 0", ok, cyc, grant); end
    host_xfer(0, 2, 0, o);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%h exp=1", timeout_err); end
  endtask
`endif

  // Reference: every drive in the round's mask is served once, in order of increasing
  // distance from the previously served drive.
  task automatic test_random();
    obs_t o;
    exp_t e;
    bit ok;
    int cyc;
    int model_last;
    logic [3:0] mask;
    logic [31:0] lba [4];
    int op [4];
    logic [7:0] din [4];
    do_reset();
    model_last = 3;
    for (int r = 0; r < 10; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int d = 0; d < 4; d++) begin
        lba[d] = $urandom;
        op[d]  = $urandom_range(0, 2);
        din[d] = 8'($urandom);
        drv_lba[32*d +: 32] = lba[d];
        drv_buff_din[8*d +: 8] = din[d];
      end
      for (int d = 0; d < 4; d++) begin
        drv_rd[d] = mask[d] && (op[d] != 1);
        drv_wr[d] = mask[d] && (op[d] != 0);
      end
      for (int k = 1; k <= 4; k++) begin
        int d;
        d = (model_last + k) % 4;
        if (mask[d]) begin
          e.idx = 2'(d);
          e.lba = lba[d];
          e.rd  = (op[d] != 1);
          e.wr  = (op[d] == 1);
          e.din = din[d];
          exp_q.push_back(e);
        end
      end
      model_last = int'(exp_q[exp_q.size()-1].idx);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        wait_req(10, ok, cyc);
        checks++; if (!ok || cyc != 1) begin errors++; $display("FAIL rnd_req r%0d got ok=%0d cyc=%0d exp 1 1", r, ok, cyc); end
        checks++; if (grant !== e.idx) begin errors++; $display("FAIL rnd_grant r%0d got=%0d exp=%0d", r, grant, e.idx); end
        checks++; if (sd_lba !== e.lba) begin errors++; $display("FAIL rnd_lba r%0d got=%h exp=%h", r, sd_lba, e.lba); end
        checks++; if (sd_rd !== e.rd || sd_wr !== e.wr) begin errors++; $display("FAIL rnd_op r%0d got=%h%h exp=%h%h", r, sd_rd, sd_wr, e.rd, e.wr); end
        host_xfer($urandom_range(0, 3), $urandom_range(1, 5), int'(e.idx), o);
        checks++; if (o.ack_or !== 4'(1 << e.idx)) begin errors++; $display("FAIL rnd_ack r%0d got=%b exp=%b", r, o.ack_or, 4'(1 << e.idx)); end
        checks++; if (o.din !== e.din) begin errors++; $display("FAIL rnd_din r%0d got=%h exp=%h", r, o.din, e.din); end
        checks++; if (o.bwr_or !== 4'(1 << e.idx) || o.bwr_stray != 0) begin errors++; $display("FAIL rnd_bwr r%0d got=%b stray=%0d exp=%b 0", r, o.bwr_or, o.bwr_stray, 4'(1 << e.idx)); end
        checks++; if (o.rel_req !== 1'b0 || o.idle_req !== 1'b0 || o.idle_busy !== 1'b0) begin
          errors++; $display("FAIL rnd_gap r%0d got req=%h%h busy=%h exp 00 0", r, o.rel_req, o.idle_req, o.idle_busy);
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RESET_N = 1'b0;
    drv_lba = '0;
    drv_rd = '0;
    drv_wr = '0;
    drv_buff_din = '0;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_buff_routing();
    test_rd_wr_same();
    test_reset_mid_xfer();
`ifdef SD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_blk_arbiter.md
# sd_blk_arbiter

Four-to-one arbiter between the per-drive SD block request ports of the floppy controller and the single MiSTer SD block channel. It picks one drive's pending sector read or write, forwards its LBA and strobe to the host, and routes the host ack, buffer write strobe and buffer read data to and from that drive only. Each transfer runs to completion before the next grant. Selection between drives is round-robin.

## Interface
Parameters:
- NUM_DRIVES, 4: number of requesting drives; legal range 2..4.
- TIMEOUT_CYCLES, 24'd16777215: watchdog limit in CLK cycles. Used only when SD_ARB_TIMEOUT_EN is defined.

Ports (one clock; reset is synchronous and active-low):
- CLK  in  1  system clock.
- RESET_N  in  1  synchronous active-low reset.
- drv_lba  in  32 x NUM_DRIVES  per-drive sector LBA; held stable by the drive while its request is high.
- drv_rd  in  NUM_DRIVES  per-drive read request; level, held until that drive sees its ack.
- drv_wr  in  NUM_DRIVES  per-drive write request; level.
- drv_ack  out  NUM_DRIVES  per-drive ack; only the granted bit can be high.
- drv_buff_wr  out  NUM_DRIVES  sd_buff_wr gated to the granted drive.
- drv_buff_din  in  8 x NUM_DRIVES  per-drive buffer read data.
- sd_lba  out  32  LBA to host.
- sd_rd  out  1  read request to host.
- sd_wr  out  1  write request to host.
- sd_ack  in  1  host ack.
- sd_buff_wr  in  1  host buffer write strobe.
- sd_buff_din  out  8  buffer data to host, taken from the granted drive.
- busy  out  1  high in every state except IDLE.
- grant  out  2  index of the current or last granted drive.
- timeout_err  out  1  sticky watchdog flag. Present only when SD_ARB_TIMEOUT_EN is defined.

## Operation
States: IDLE, REQ, XFER, RELEASE, FLUSH.

- **IDLE**
  - A drive is pending when drv_rd[i] or drv_wr[i] is high.
  - The arbiter picks the first pending drive, searching from (last grant + 1) mod NUM_DRIVES upward.
  - It registers grant, sd_lba = drv_lba[grant], and the operation, then moves to REQ.
  - If a drive has both rd and wr high, the operation is a read.
- **REQ**
  - sd_rd or sd_wr is high.
  - Once asserted to the host, a request is never retracted. If the drive drops its request, the arbiter keeps waiting.
  - On sd_ack = 1, clear sd_rd and sd_wr and move to XFER.
- **XFER**
  - drv_ack[grant] = sd_ack.
  - drv_buff_wr[grant] = sd_buff_wr.
  - sd_buff_din = drv_buff_din[grant].
  - On sd_ack = 0, move to RELEASE.
- **RELEASE**
  - Lasts one cycle, all outputs idle, then go to IDLE.
  - This guarantees at least one cycle gap between grants.
- **FLUSH**
  - Entered on the first cycle after reset.
  - If sd_ack is high (a host transfer was in progress when reset hit), stay here and ignore the ack.
  - Move to IDLE when sd_ack = 0.

Routing:
- drv_ack, drv_buff_wr and sd_buff_din are combinational from grant and state.
- Non-granted drv_ack and drv_buff_wr bits are 0.
- sd_buff_din is 8'h00 outside REQ and XFER.
- The sd_buff_addr and sd_buff_dout buses are wired directly to all drives and are not handled here.

Reset values:
- sd_rd, sd_wr, drv_ack, drv_buff_wr = 0.
- sd_lba = 0, grant = 0, busy = 0, timeout_err = 0.
- State = FLUSH.

## Timing
- Request seen high in IDLE at cycle N: sd_rd/sd_wr and sd_lba registered high at N+1.
- sd_ack rises at cycle M: drv_ack[grant] high in the same cycle (combinational); sd_rd/sd_wr low at M+1.
- sd_ack falls at cycle K: RELEASE at K+1, IDLE at K+2. The earliest next host request is at K+3.
- Requests arriving during REQ, XFER or RELEASE wait. None are dropped, because drives hold their requests.
- grant is a 2-bit counter that wraps modulo NUM_DRIVES.

## Configuration
Macro: SD_ARB_TIMEOUT_EN.
- **Defined:**
  - A 24-bit counter clears on entry to REQ and increments each cycle in REQ and XFER.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set (sticky until reset), sd_rd and sd_wr drop, and the state goes to FLUSH.
  - The granted drive gets no ack. It keeps its request and is re-arbitrated.
- **Not defined:** no counter and no timeout_err port. The arbiter waits indefinitely in REQ and XFER.

## Structure
- Shared package:
  - state enum arb_state_t (IDLE, REQ, XFER, RELEASE, FLUSH);
  - localparam MAX_DRIVES = 4;
  - TIMEOUT width constant.
- One sub-module, rr_pick: combinational round-robin selector taking a pending mask and the last grant, producing a valid bit and an index. It is reusable elsewhere.

## Test plan
- **Single read:** drv_rd[2] = 1, lba 0x00000123; host acks after 5 cycles for 10 cycles → sd_rd high the cycle after the request, sd_lba = 0x123, drv_ack = 4'b0100 only while sd_ack is high, grant = 2.
- **Contention:** drv_rd = 4'b1111 after reset, each request dropped after its ack → grant order 0,1,2,3, each transfer separated by ≥1 idle cycle.
- **Buffer routing:** during a write on drive 1 with drv_buff_din[1] = 0xA5 and the others 0xFF → sd_buff_din = 0xA5; a sd_buff_wr pulse appears only on drv_buff_wr[1].
- **rd+wr same drive:** drv_rd[3] = drv_wr[3] = 1 → sd_rd = 1, sd_wr = 0.
- **Reset mid-XFER:** RESET_N low for 1 cycle while sd_ack = 1 → all outputs 0; no drv_ack while sd_ack stays high; the next grant is issued only after sd_ack falls.
- **Timeout (SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 100):** no sd_ack → sd_rd drops at cycle 100 after entering REQ, timeout_err = 1, and the request is re-issued after FLUSH.
